// File: rtl/branch_redirect_arbiter_if.sv
// Redirect/repair bundle between the flush requesters, fetch/BPU and the redirect arbiter.
// The slave modport is the arbiter's view; master is the requester/fetch side.
interface branch_redirect_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned CKPT_W = 64,
    parameter int unsigned ACT_W  = 4
);
    logic              exc_req_i;
    logic [ADDR_W-1:0] exc_dest_i;
    logic              sba_req_i;
    logic [ADDR_W-1:0] sba_dest_i;
    logic [CKPT_W-1:0] sba_ckpt_i;
    logic [ACT_W-1:0]  sba_act_i;
    logic              fba_req_i;
    logic [ADDR_W-1:0] fba_dest_i;
    logic [CKPT_W-1:0] fba_ckpt_i;
    logic [ACT_W-1:0]  fba_act_i;
    logic              sba_grant_o;
    logic              fba_grant_o;
    logic              fba_kill_o;
    logic              redir_valid_o;
    logic              redir_ready_i;
    logic [ADDR_W-1:0] redir_pc_o;
    logic              repair_en_o;
    logic [CKPT_W-1:0] repair_ckpt_o;
    logic [ACT_W-1:0]  repair_act_o;
    logic              fe_stall_o;
    logic              busy_o;

    modport master (
        output exc_req_i, exc_dest_i,
        output sba_req_i, sba_dest_i, sba_ckpt_i, sba_act_i,
        output fba_req_i, fba_dest_i, fba_ckpt_i, fba_act_i,
        output redir_ready_i,
        input  sba_grant_o, fba_grant_o, fba_kill_o,
        input  redir_valid_o, redir_pc_o,
        input  repair_en_o, repair_ckpt_o, repair_act_o,
        input  fe_stall_o, busy_o
    );

    modport slave (
        input  exc_req_i, exc_dest_i,
        input  sba_req_i, sba_dest_i, sba_ckpt_i, sba_act_i,
        input  fba_req_i, fba_dest_i, fba_ckpt_i, fba_act_i,
        input  redir_ready_i,
        output sba_grant_o, fba_grant_o, fba_kill_o,
        output redir_valid_o, redir_pc_o,
        output repair_en_o, repair_ckpt_o, repair_act_o,
        output fe_stall_o, busy_o
    );
endinterface

// File: rtl/branch_redirect_arbiter.sv
// Arbitrates exception / second-stage / first-stage flushes onto the single fetch redirect
// port, then replays the winner's checkpoint into the BPU over REPAIR_CYCLES cycles.
module branch_redirect_arbiter #(
    parameter int unsigned ADDR_W        = 32,
    parameter int unsigned CKPT_W        = 64,
    parameter int unsigned ACT_W         = 4,
    parameter int unsigned REPAIR_CYCLES = 2
) (
    input logic                      clk,
    input logic                      rst,
    branch_redirect_arbiter_if.slave arb_io
);

    localparam int unsigned CntW = (REPAIR_CYCLES > 1) ? $clog2(REPAIR_CYCLES) : 1;

    typedef enum logic [1:0] {StIdle, StHold, StRepair} state_e;
    // Encoded so that a larger value means an architecturally older flush.
    typedef enum logic [1:0] {SrcFba = 2'd0, SrcSba = 2'd1, SrcExc = 2'd2} src_e;

    state_e            state_q, state_d;
    src_e              src_q, src_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [CKPT_W-1:0] ckpt_q, ckpt_d;
    logic [ACT_W-1:0]  act_q, act_d;
    logic [CntW-1:0]   cnt_q, cnt_d;

    src_e              win_src;
    logic [ADDR_W-1:0] win_pc;
    logic [CKPT_W-1:0] win_ckpt;
    logic [ACT_W-1:0]  win_act;
    logic              req_any;
    logic              capture;
    logic              kill_held;
    logic              fba_granted;

    // Oldest pending request; exceptions never carry a repair.
    always_comb begin
        req_any  = arb_io.exc_req_i | arb_io.sba_req_i | arb_io.fba_req_i;
        win_src  = SrcFba;
        win_pc   = arb_io.fba_dest_i;
        win_ckpt = arb_io.fba_ckpt_i;
        win_act  = arb_io.fba_act_i;
        if (arb_io.exc_req_i) begin
            win_src  = SrcExc;
            win_pc   = arb_io.exc_dest_i;
            win_ckpt = '0;
            win_act  = '0;
        end else if (arb_io.sba_req_i) begin
            win_src  = SrcSba;
            win_pc   = arb_io.sba_dest_i;
            win_ckpt = arb_io.sba_ckpt_i;
            win_act  = arb_io.sba_act_i;
        end
    end

    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        pc_d      = pc_q;
        ckpt_d    = ckpt_q;
        act_d     = act_q;
        cnt_d     = cnt_q;
        capture   = 1'b0;
        kill_held = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (req_any) begin
                    capture = 1'b1;
                    state_d = StHold;
                end
            end
            StHold: begin
                // An older flush supersedes the held one even if fetch takes it this cycle.
                if (req_any && (win_src > src_q)) begin
                    capture   = 1'b1;
                    kill_held = (src_q == SrcFba);
                end else if (arb_io.redir_ready_i) begin
                    if (act_q[0]) begin
                        state_d = StRepair;
                        cnt_d   = CntW'(REPAIR_CYCLES - 1);
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StRepair: begin
                if (arb_io.exc_req_i) begin
                    capture = 1'b1;
                    state_d = StHold;
                end else if (cnt_q == '0) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        if (!rst) begin
            capture   = 1'b0;
            kill_held = 1'b0;
        end

        if (capture) begin
            src_d  = win_src;
            pc_d   = win_pc;
            ckpt_d = win_ckpt;
            act_d  = win_act;
        end

        // Held entry is cleared on return to idle so the outputs read zero there.
        if (state_d == StIdle) begin
            src_d  = SrcFba;
            pc_d   = '0;
            ckpt_d = '0;
            act_d  = '0;
            cnt_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
            src_q   <= SrcFba;
            pc_q    <= '0;
            ckpt_q  <= '0;
            act_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            pc_q    <= pc_d;
            ckpt_q  <= ckpt_d;
            act_q   <= act_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        fba_granted        = capture && (win_src == SrcFba);
        arb_io.sba_grant_o = capture && (win_src == SrcSba);
        arb_io.fba_grant_o = fba_granted;
        // FBA is squashed whenever an older flush wins or is already held.
        arb_io.fba_kill_o  = rst && (kill_held ||
                             (arb_io.fba_req_i && !fba_granted &&
                              (arb_io.exc_req_i || arb_io.sba_req_i ||
                               ((state_q != StIdle) && (src_q != SrcFba)))));
        arb_io.redir_valid_o = (state_q == StHold);
        arb_io.repair_en_o   = (state_q == StRepair);
        arb_io.fe_stall_o    = (state_q != StIdle);
        arb_io.busy_o        = (state_q != StIdle);
        arb_io.redir_pc_o    = pc_q;
        arb_io.repair_ckpt_o = ckpt_q;
        arb_io.repair_act_o  = act_q;
    end

endmodule

// File: tb/tb_branch_redirect_arbiter.sv
// Directed-vector bench for branch_redirect_arbiter: inputs change 1ns after the rising
// edge, outputs are sampled on the falling edge.
module tb_branch_redirect_arbiter;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned CKPT_W = 64;
    localparam int unsigned ACT_W  = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    branch_redirect_arbiter_if #(.ADDR_W(ADDR_W), .CKPT_W(CKPT_W), .ACT_W(ACT_W)) arb ();

    branch_redirect_arbiter #(
        .ADDR_W(ADDR_W), .CKPT_W(CKPT_W), .ACT_W(ACT_W), .REPAIR_CYCLES(2)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .arb_io (arb.slave)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic clear_reqs();
        arb.exc_req_i = 1'b0;
        arb.sba_req_i = 1'b0;
        arb.fba_req_i = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".valid"}, 64'(arb.redir_valid_o), 64'd0);
        check({tag, ".rep_en"}, 64'(arb.repair_en_o), 64'd0);
        check({tag, ".stall"}, 64'(arb.fe_stall_o), 64'd0);
        check({tag, ".busy"}, 64'(arb.busy_o), 64'd0);
        check({tag, ".pc"}, 64'(arb.redir_pc_o), 64'd0);
        check({tag, ".ckpt"}, 64'(arb.repair_ckpt_o), 64'd0);
        check({tag, ".act"}, 64'(arb.repair_act_o), 64'd0);
    endtask

    initial begin
        clear_reqs();
        arb.exc_dest_i    = 32'hBFC0_0000;
        arb.sba_dest_i    = 32'hBFC0_0380;
        arb.sba_ckpt_i    = 64'h1234_5678_9ABC_DEF0;
        arb.sba_act_i     = 4'h1;
        arb.fba_dest_i    = 32'h8000_1000;
        arb.fba_ckpt_i    = 64'h0F0F_0000_1111_2222;
        arb.fba_act_i     = 4'h1;
        arb.redir_ready_i = 1'b0;

        // Reset
        tick(); tick();
        mid();
        check_idle("rst");
        check("rst.sgnt", 64'(arb.sba_grant_o), 64'd0);
        tick();
        rst = 1'b1;

        // 1: SBA with repair, fetch always ready
        arb.sba_req_i = 1'b1;
        arb.redir_ready_i = 1'b1;
        mid();
        check("t1.T0.sgnt", 64'(arb.sba_grant_o), 64'd1);
        check("t1.T0.valid", 64'(arb.redir_valid_o), 64'd0);
        check("t1.T0.busy", 64'(arb.busy_o), 64'd0);
        tick();
        arb.sba_req_i = 1'b0;
        mid();
        check("t1.T1.valid", 64'(arb.redir_valid_o), 64'd1);
        check("t1.T1.pc", 64'(arb.redir_pc_o), 64'hBFC0_0380);
        check("t1.T1.sgnt", 64'(arb.sba_grant_o), 64'd0);
        check("t1.T1.rep_en", 64'(arb.repair_en_o), 64'd0);
        check("t1.T1.stall", 64'(arb.fe_stall_o), 64'd1);
        tick();
        mid();
        check("t1.T2.rep_en", 64'(arb.repair_en_o), 64'd1);
        check("t1.T2.valid", 64'(arb.redir_valid_o), 64'd0);
        check("t1.T2.ckpt", arb.repair_ckpt_o, 64'h1234_5678_9ABC_DEF0);
        check("t1.T2.act", 64'(arb.repair_act_o), 64'd1);
        tick();
        mid();
        check("t1.T3.rep_en", 64'(arb.repair_en_o), 64'd1);
        check("t1.T3.stall", 64'(arb.fe_stall_o), 64'd1);
        tick();
        mid();
        check_idle("t1.T4");
        tick();

        // 2: SBA and FBA together; later FBA arrives against held SBA
        arb.redir_ready_i = 1'b0;
        arb.sba_act_i = 4'h0;
        arb.sba_req_i = 1'b1;
        arb.fba_req_i = 1'b1;
        mid();
        check("t2.sgnt", 64'(arb.sba_grant_o), 64'd1);
        check("t2.fgnt", 64'(arb.fba_grant_o), 64'd0);
        check("t2.kill", 64'(arb.fba_kill_o), 64'd1);
        tick();
        clear_reqs();
        mid();
        check("t2.H.pc", 64'(arb.redir_pc_o), 64'hBFC0_0380);
        check("t2.H.kill", 64'(arb.fba_kill_o), 64'd0);
        tick();
        arb.fba_req_i = 1'b1;
        mid();
        check("t2.late.fgnt", 64'(arb.fba_grant_o), 64'd0);
        check("t2.late.kill", 64'(arb.fba_kill_o), 64'd1);
        tick();
        clear_reqs();
        arb.redir_ready_i = 1'b1;
        mid();
        check("t2.acc.pc", 64'(arb.redir_pc_o), 64'hBFC0_0380);
        tick();
        arb.redir_ready_i = 1'b0;
        mid();
        check_idle("t2.end");
        tick();

        // 3: held FBA overwritten by SBA while fetch stalls
        arb.fba_req_i = 1'b1;
        mid();
        check("t3.fgnt", 64'(arb.fba_grant_o), 64'd1);
        check("t3.kill0", 64'(arb.fba_kill_o), 64'd0);
        tick();
        clear_reqs();
        mid();
        check("t3.H1.pc", 64'(arb.redir_pc_o), 64'h8000_1000);
        check("t3.H1.kill", 64'(arb.fba_kill_o), 64'd0);
        tick();
        arb.sba_req_i = 1'b1;
        mid();
        check("t3.H2.sgnt", 64'(arb.sba_grant_o), 64'd1);
        check("t3.H2.kill", 64'(arb.fba_kill_o), 64'd1);
        tick();
        clear_reqs();
        mid();
        check("t3.H3.pc", 64'(arb.redir_pc_o), 64'hBFC0_0380);
        check("t3.H3.kill", 64'(arb.fba_kill_o), 64'd0);
        check("t3.H3.valid", 64'(arb.redir_valid_o), 64'd1);
        tick();
        arb.redir_ready_i = 1'b1;
        mid();
        check("t3.acc.pc", 64'(arb.redir_pc_o), 64'hBFC0_0380);
        check("t3.acc.valid", 64'(arb.redir_valid_o), 64'd1);
        tick();
        arb.redir_ready_i = 1'b0;
        mid();
        check_idle("t3.end");
        tick();

        // 4: exception aborts a restore in its first repair cycle
        arb.sba_act_i = 4'h1;
        arb.sba_req_i = 1'b1;
        arb.redir_ready_i = 1'b1;
        mid();
        check("t4.sgnt", 64'(arb.sba_grant_o), 64'd1);
        tick();
        clear_reqs();
        tick();
        arb.redir_ready_i = 1'b0;
        arb.exc_req_i = 1'b1;
        mid();
        check("t4.R1.rep_en", 64'(arb.repair_en_o), 64'd1);
        check("t4.R1.sgnt", 64'(arb.sba_grant_o), 64'd0);
        tick();
        clear_reqs();
        mid();
        check("t4.H.rep_en", 64'(arb.repair_en_o), 64'd0);
        check("t4.H.valid", 64'(arb.redir_valid_o), 64'd1);
        check("t4.H.pc", 64'(arb.redir_pc_o), 64'hBFC0_0000);
        check("t4.H.act", 64'(arb.repair_act_o), 64'd0);
        check("t4.H.ckpt", arb.repair_ckpt_o, 64'd0);
        tick();
        arb.redir_ready_i = 1'b1;
        tick();
        arb.redir_ready_i = 1'b0;
        mid();
        check_idle("t4.end");
        tick();

        // 5: act=0 goes straight back to idle
        arb.sba_act_i = 4'h0;
        arb.sba_req_i = 1'b1;
        arb.redir_ready_i = 1'b1;
        mid();
        check("t5.sgnt", 64'(arb.sba_grant_o), 64'd1);
        tick();
        clear_reqs();
        mid();
        check("t5.valid", 64'(arb.redir_valid_o), 64'd1);
        check("t5.rep_en", 64'(arb.repair_en_o), 64'd0);
        tick();
        arb.redir_ready_i = 1'b0;
        mid();
        check_idle("t5.end");
        tick();

        // 6: reset in HOLD with a pending request
        arb.fba_req_i = 1'b1;
        mid();
        check("t6.fgnt", 64'(arb.fba_grant_o), 64'd1);
        tick();
        clear_reqs();
        arb.sba_req_i = 1'b1;
        rst = 1'b0;
        mid();
        check("t6.rst.sgnt", 64'(arb.sba_grant_o), 64'd0);
        tick();
        mid();
        check_idle("t6.after");
        tick();
        rst = 1'b1;
        mid();
        check("t6.re.sgnt", 64'(arb.sba_grant_o), 64'd1);
        check("t6.re.valid", 64'(arb.redir_valid_o), 64'd0);
        tick();
        clear_reqs();
        mid();
        check("t6.H.pc", 64'(arb.redir_pc_o), 64'hBFC0_0380);
        check("t6.H.valid", 64'(arb.redir_valid_o), 64'd1);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
